// File: rtl/rat_pkg.sv
// Shared definitions for the rat maze path tracker: move directions,
// tracker states and default maze geometry.
package rat_pkg;

    localparam int COORD_W_DEF   = 4;
    localparam int STEP_W_DEF    = 8;
    localparam int GOAL_X_DEF    = 15;
    localparam int GOAL_Y_DEF    = 15;
    localparam int MAX_STEPS_DEF = 255;

    // Must match the encoding used by the rat Controller/DataPath.
    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        LEFT  = 2'b10,
        DOWN  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_TRACK   = 2'b01,
        S_ARRIVED = 2'b10,
        S_ERR     = 2'b11
    } trk_state_e;

endpackage

// File: rtl/rat_path_tracker_if.sv
// Move stream in, replayed position and status flags out.
interface rat_path_tracker_if #(
    parameter int COORD_W = 4,
    parameter int STEP_W  = 8
);
    logic               start;
    logic               move_valid;
    logic [1:0]         move;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic [STEP_W-1:0]  steps;
    logic               busy;
    logic               arrived;
    logic               error;

    modport master (
        output start, move_valid, move,
        input  pos_x, pos_y, steps, busy, arrived, error
    );

    modport slave (
        input  start, move_valid, move,
        output pos_x, pos_y, steps, busy, arrived, error
    );
endinterface

// File: rtl/rat_step_unit.sv
// Combinational single-step move evaluation: next coordinates and an
// out-of-bounds flag for moves that would leave the maze.
module rat_step_unit
    import rat_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  dir_e               move,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               out_of_bounds
);
    localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);
    localparam logic [COORD_W-1:0] MAXC = '1;

    always_comb begin
        next_x        = x;
        next_y        = y;
        out_of_bounds = 1'b0;
        case (move)
            UP:    if (y == '0)   out_of_bounds = 1'b1; else next_y = y - ONE;
            RIGHT: if (x == MAXC) out_of_bounds = 1'b1; else next_x = x + ONE;
            LEFT:  if (x == '0)   out_of_bounds = 1'b1; else next_x = x - ONE;
            DOWN:  if (y == MAXC) out_of_bounds = 1'b1; else next_y = y + ONE;
            default: out_of_bounds = 1'b0;
        endcase
    end
endmodule

// File: rtl/rat_path_tracker.sv
// Replays the rat Run-phase move stream on a local X/Y position and reports
// steps, goal arrival and illegal moves. Optional macro: STEP_LIMIT_EN.
//
// state     | meaning
// S_IDLE    | after reset, moves ignored until start
// S_TRACK   | armed, each valid move is evaluated
// S_ARRIVED | goal reached, outputs frozen until start
// S_ERR     | illegal move rejected, outputs frozen until start
module rat_path_tracker
    import rat_pkg::*;
#(
    parameter int COORD_W   = COORD_W_DEF,
    parameter int STEP_W    = STEP_W_DEF,
    parameter int GOAL_X    = GOAL_X_DEF,
    parameter int GOAL_Y    = GOAL_Y_DEF,
    parameter int MAX_STEPS = MAX_STEPS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    rat_path_tracker_if.slave bus
);
`ifdef STEP_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif
    localparam logic [COORD_W-1:0] GX       = COORD_W'(GOAL_X);
    localparam logic [COORD_W-1:0] GY       = COORD_W'(GOAL_Y);
    localparam logic [STEP_W-1:0]  STEP_MAX = STEP_W'(MAX_STEPS);
    localparam logic [STEP_W-1:0]  STEP_ONE = STEP_W'(1);

    trk_state_e         state;
    logic [COORD_W-1:0] pos_x, pos_y, next_x, next_y;
    logic [STEP_W-1:0]  steps;
    logic               busy, arrived, error;
    logic               oob, limit_hit;

    rat_step_unit #(.COORD_W(COORD_W)) u_step (
        .x             (pos_x),
        .y             (pos_y),
        .move          (dir_e'(bus.move)),
        .next_x        (next_x),
        .next_y        (next_y),
        .out_of_bounds (oob)
    );

    assign limit_hit = LIMIT_EN && (steps == STEP_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pos_x   <= '0;
            pos_y   <= '0;
            steps   <= '0;
            busy    <= 1'b0;
            arrived <= 1'b0;
            error   <= 1'b0;
        end else if (bus.start) begin
            // Start wins over a concurrent move, from any state.
            state   <= S_TRACK;
            pos_x   <= '0;
            pos_y   <= '0;
            steps   <= '0;
            busy    <= 1'b1;
            arrived <= 1'b0;
            error   <= 1'b0;
        end else if (state == S_TRACK && bus.move_valid) begin
            if (oob || limit_hit) begin
                error <= 1'b1;
                busy  <= 1'b0;
                state <= S_ERR;
            end else begin
                pos_x <= next_x;
                pos_y <= next_y;
                if (steps != '1) steps <= steps + STEP_ONE;
                if (next_x == GX && next_y == GY) begin
                    arrived <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_ARRIVED;
                end
            end
        end
    end

    assign bus.pos_x   = pos_x;
    assign bus.pos_y   = pos_y;
    assign bus.steps   = steps;
    assign bus.busy    = busy;
    assign bus.arrived = arrived;
    assign bus.error   = error;
endmodule

// File: tb/tb_rat_path_tracker.sv
// Scoreboard bench for rat_path_tracker: a driver updates an integer-level
// model of the maze walk and queues expected outputs; a monitor compares.
module tb_rat_path_tracker;
    localparam int CW   = 4;
    localparam int SW   = 8;
    localparam int MAXS = 4;
`ifdef STEP_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [SW-1:0] steps;
        logic          busy;
        logic          arrived;
        logic          error;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rat_path_tracker_if #(.COORD_W(CW), .STEP_W(SW)) bus ();

    rat_path_tracker #(
        .COORD_W(CW), .STEP_W(SW), .GOAL_X(15), .GOAL_Y(15), .MAX_STEPS(MAXS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;

    // Reference model: plain integer walk on a 16x16 grid.
    int mx, my, ms;
    bit armed, marr, merr;

    task automatic cyc(input bit r, input bit s, input bit v, input logic [1:0] m);
        int nx, ny;
        obs_t e;
        @(negedge clk);
        rst = r; bus.start = s; bus.move_valid = v; bus.move = m;
        if (r) begin
            mx = 0; my = 0; ms = 0; armed = 0; marr = 0; merr = 0;
        end else if (s) begin
            mx = 0; my = 0; ms = 0; armed = 1; marr = 0; merr = 0;
        end else if (armed && v) begin
            nx = mx; ny = my;
            case (m)
                2'b00: ny = my - 1;
                2'b01: nx = mx + 1;
                2'b10: nx = mx - 1;
                default: ny = my + 1;
            endcase
            if (nx < 0 || nx > 15 || ny < 0 || ny > 15 || (LIMIT && ms == MAXS)) begin
                merr = 1; armed = 0;
            end else begin
                mx = nx; my = ny;
                if (ms < 255) ms = ms + 1;
                if (mx == 15 && my == 15) begin
                    marr = 1; armed = 0;
                end
            end
        end
        e.x = mx[CW-1:0];
        e.y = my[CW-1:0];
        e.steps = ms[SW-1:0];
        e.busy = armed;
        e.arrived = marr;
        e.error = merr;
        q.push_back(e);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{bus.pos_x, bus.pos_y, bus.steps, bus.busy, bus.arrived, bus.error};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL obs cyc=%0d act x=%0d y=%0d st=%0d b=%0d a=%0d e=%0d exp x=%0d y=%0d st=%0d b=%0d a=%0d e=%0d",
                             cycle, a.x, a.y, a.steps, a.busy, a.arrived, a.error,
                             e.x, e.y, e.steps, e.busy, e.arrived, e.error);
                end
            end
        end
    end

    initial begin : driver
        logic [1:0] m;
        rst = 1'b1; bus.start = 1'b0; bus.move_valid = 1'b0; bus.move = 2'b00;
        mx = 0; my = 0; ms = 0; armed = 0; marr = 0; merr = 0;

        cyc(1, 0, 0, 2'b00);
        cyc(1, 1, 1, 2'b01);                // start lost under reset
        cyc(0, 0, 1, 2'b01);                // idle ignores moves
        // basic walk
        cyc(0, 1, 0, 2'b00);
        repeat (3) cyc(0, 0, 1, 2'b01);
        repeat (2) cyc(0, 0, 1, 2'b11);
        cyc(0, 0, 0, 2'b11);
        // illegal first move
        cyc(0, 1, 0, 2'b00);
        cyc(0, 0, 1, 2'b00);
        cyc(0, 0, 1, 2'b01);
        cyc(0, 0, 1, 2'b11);
        // corner to corner, then a move after arrival
        cyc(0, 1, 0, 2'b00);
        repeat (15) cyc(0, 0, 1, 2'b01);
        repeat (15) cyc(0, 0, 1, 2'b11);
        cyc(0, 0, 1, 2'b10);
        // restart with concurrent move
        cyc(0, 1, 0, 2'b00);
        repeat (2) cyc(0, 0, 1, 2'b01);
        cyc(0, 1, 1, 2'b01);
        cyc(0, 0, 1, 2'b11);
        // reset mid-track at (4,4)
        cyc(0, 1, 0, 2'b00);
        repeat (4) cyc(0, 0, 1, 2'b01);
        repeat (4) cyc(0, 0, 1, 2'b11);
        cyc(1, 0, 1, 2'b01);
        cyc(0, 0, 1, 2'b01);
        cyc(0, 0, 1, 2'b11);
        // right/left oscillation: step limit or no limit
        cyc(0, 1, 0, 2'b00);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, (i % 2 == 0) ? 2'b01 : 2'b10);
        cyc(0, 0, 0, 2'b00);
        // long oscillation to hit step saturation
        cyc(0, 1, 0, 2'b00);
        for (int i = 0; i < 262; i++) cyc(0, 0, 1, (i % 2 == 0) ? 2'b01 : 2'b10);
        // random traffic biased toward the goal
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(9))
                0, 1, 2, 3: m = 2'b01;
                4, 5, 6, 7: m = 2'b11;
                default:    m = 2'($urandom_range(3));
            endcase
            cyc(($urandom_range(199) == 0), ($urandom_range(59) == 0),
                ($urandom_range(3) != 0), m);
        end
        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain act=%0d pending exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rat_path_tracker.md
Name: rat_path_tracker

Overview:
- Downstream consumer of the intelligent-rat top level. Accepts the 2-bit Move stream emitted during the Run phase after Done and replays it on a local 4-bit X/Y position register pair.
- Reports the final position, the step count, goal arrival, and illegal moves that leave the 16x16 maze.
- Feeds the board-level display and the self-check logic.

Parameters:
- COORD_W, 4, width of X and Y coordinates; maze is 2^COORD_W square.
- STEP_W, 8, width of the step counter.
- GOAL_X, 15, X coordinate of the maze exit.
- GOAL_Y, 15, Y coordinate of the maze exit.
- MAX_STEPS, 255, step limit; used only with STEP_LIMIT_EN.

Ports:
- Clk  input  1  system clock.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse; clears position, count and flags, then arms tracking.
- Move_valid  input  1  Move is valid this cycle (rat Run-phase strobe).
- Move  input  2  direction code.
- Pos_X  output  COORD_W  current X.
- Pos_Y  output  COORD_W  current Y.
- Steps  output  STEP_W  accepted moves since Start.
- Busy  output  1  tracker armed and accepting moves.
- Arrived  output  1  sticky; position equals (GOAL_X,GOAL_Y).
- Error  output  1  sticky; illegal move rejected.

Behaviour:
- Direction encoding, fixed in the package:
  - 2'b00 = up, Y-1.
  - 2'b01 = right, X+1.
  - 2'b10 = left, X-1.
  - 2'b11 = down, Y+1.
- All state updates on the rising edge of Clk. Rst has priority over every input.
- Reset values: Pos_X=0, Pos_Y=0, Steps=0, Busy=0, Arrived=0, Error=0; FSM in IDLE.
- FSM states: IDLE, TRACK, ARRIVED, ERR.
  - IDLE: Move_valid ignored. Start -> TRACK; same edge clears position, Steps and flags.
  - TRACK: Busy=1. Each cycle with Move_valid=1, evaluate the move.
    - Target coordinate out of range (X=0 left, X=max right, Y=0 up, Y=max down): position and Steps unchanged, Error=1, -> ERR.
    - Otherwise: position updates, Steps increments.
    - If the new position equals the goal: Arrived=1 on the same edge, -> ARRIVED.
  - ARRIVED and ERR: Busy=0. Further Move_valid ignored; outputs hold. Start re-arms into TRACK with a clear.
- Start while in TRACK: restart. Clear everything and stay in TRACK; the concurrent Move is discarded.
- Latency: one cycle. Outputs reflect a move on the edge that samples it. No back-pressure; one move accepted per cycle.
- Steps saturates at all-ones and never wraps. Saturation alone is not an error.
- Rst mid-tracking: immediate return to reset values on the next edge.
- Start pulse that coincides with Rst: lost.

Optional Feature:
- Macro: STEP_LIMIT_EN.
- Defined: in TRACK, a valid move arriving when Steps==MAX_STEPS is rejected. Error=1, -> ERR, position and Steps unchanged.
- Undefined: no step limit; only saturation applies. MAX_STEPS unused.

Decomposition:
- Shared package rat_pkg holds:
  - typedef enum for direction codes (UP, RIGHT, LEFT, DOWN), matching the Controller/DataPath encoding.
  - typedef enum for tracker states.
  - Default maze size and goal constants.
- One sub-module: rat_step_unit, combinational. Inputs: X, Y, Move. Outputs: next X, next Y, out_of_bounds.
- FSM, counters and sticky flags stay in the top of this block.

Test Plan:
- Rst, Start, then moves RIGHT x3 and DOWN x2 -> Pos=(3,2), Steps=3 then 5, Busy=1, Error=0.
- From (0,0), send UP -> Error=1, Pos=(0,0), Steps=0, Busy=0; later moves ignored.
- 15 RIGHT then 15 DOWN -> Arrived=1 on the edge of the 30th move, Steps=30, Busy=0; a 31st move leaves all outputs unchanged.
- After 2 moves, assert Start together with Move_valid=1 -> Pos=(0,0), Steps=0, Busy=1; that move is not counted.
- Rst asserted mid-tracking at (4,4) -> next edge all outputs 0, state IDLE; Move_valid ignored until Start.
- STEP_LIMIT_EN with MAX_STEPS=4: alternate RIGHT/LEFT x5 -> 5th move rejected, Steps=4, Error=1. Without the macro: Steps=5, Error=0.
